// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: valid/ready plus payload.
// The master drives valid and payload, and the slave drives ready.
interface pipe_stage_reg_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_DATA = 3,
  parameter int INSTR_W  = 19,
  parameter int CTRL_W   = 2
);
  logic                       valid;
  logic                       ready;
  logic [NUM_DATA*DATA_W-1:0] data;
  logic [INSTR_W-1:0]         instr;
  logic [CTRL_W-1:0]          ctrl;

  modport master (
    output valid, data, instr, ctrl,
    input  ready
  );

  modport slave (
    input  valid, data, instr, ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with an optional skid entry.
// Define PIPE_STAGE_REG_SKID_EN to get two entries and a registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W   = 8,
  parameter int NUM_DATA = 3,
  parameter int INSTR_W  = 19,
  parameter int CTRL_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pipe_stage_reg_if.slave   in_if,
  pipe_stage_reg_if.master  out_if,
  output logic [1:0]        occupancy
);
  localparam int PAY_W = NUM_DATA*DATA_W + INSTR_W + CTRL_W;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_q;
  logic             accept;
  logic             rel;

  assign in_pay = {in_if.data, in_if.instr, in_if.ctrl};
  assign {out_if.data, out_if.instr, out_if.ctrl} = main_q;
  assign rel = out_if.valid & out_if.ready;
  assign accept = in_if.valid & in_if.ready;

`ifdef PIPE_STAGE_REG_SKID_EN
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PAY_W-1:0] skid_q;
  logic             ready_q;
  logic             main_ld;
  logic             main_from_skid;
  logic             skid_ld;

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (!flush) begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = FULL;
            main_ld = 1'b1;
          end
        end
        FULL: begin
          if (accept && rel) begin
            main_ld = 1'b1;
          end else if (accept) begin
            state_d = SKID;
            skid_ld = 1'b1;
          end else if (rel) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (rel) begin
            state_d        = FULL;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      // Ready looks only at the next state, never at out_ready.
      ready_q <= (state_d != SKID);
      if (main_ld) main_q <= main_from_skid ? skid_q : in_pay;
      if (skid_ld) skid_q <= in_pay;
    end
  end

  assign in_if.ready  = ready_q;
  assign out_if.valid = (state_q != EMPTY);
  assign occupancy    = (state_q == SKID) ? 2'd2 :
                        (state_q == FULL) ? 2'd1 : 2'd0;
`else
  logic valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        main_q  <= in_pay;
      end else if (rel) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign in_if.ready  = out_if.ready | ~valid_q;
  assign out_if.valid = valid_q;
  assign occupancy    = {1'b0, valid_q};
`endif
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 8: width of one datapath lane.
REQ-002 Parameter NUM_DATA, default 3: number of datapath lanes (mem data, alu out, shift out).
REQ-003 Parameter INSTR_W, default 19: instruction field width.
REQ-004 Parameter CTRL_W, default 2: control field width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  synchronous kill of all held entries.
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  stage accepts an entry this cycle.
REQ-010 in_data  input  NUM_DATA*DATA_W  lane 0 in LSBs.
REQ-011 in_instr  input  INSTR_W  instruction tag.
REQ-012 in_ctrl  input  CTRL_W  control bits.
REQ-013 out_valid  output  1  downstream entry present.
REQ-014 out_ready  input  1  downstream accepts.
REQ-015 out_data / out_instr / out_ctrl  output  same widths as inputs  head entry payload.
REQ-016 occupancy  output  2  entries held (0..2).

Function
REQ-017 Accept = in_valid & in_ready; release = out_valid & out_ready; payload = {data, instr, ctrl} moved as one word.
REQ-018 States: EMPTY (occ 0), FULL (main only, occ 1), SKID (main+skid, occ 2); out_valid = (state != EMPTY).
REQ-019 in_ready is registered: 1 in EMPTY and FULL, 0 in SKID; no combinational path from out_ready to in_ready.
REQ-020 EMPTY: accept -> FULL, entry into main, visible on outputs next cycle (latency 1).
REQ-021 FULL: accept & release -> FULL, main replaced; accept only -> SKID, entry into skid; release only -> EMPTY.
REQ-022 SKID: release -> FULL, skid moves to main same edge; no release -> hold.
REQ-023 Entries leave in strict arrival order; no entry dropped or duplicated except by flush.
REQ-024 flush high: next state EMPTY, both valid bits cleared, any same-cycle accept discarded; flush beats accept and release.
REQ-025 Payload registers not cleared by flush or on release; out_* hold last value while out_valid = 0.
REQ-026 occupancy equals the number of valid entries, updated on the same edge as state.

Reset
REQ-027 reset asserted: state EMPTY, out_valid 0, occupancy 0, in_ready 1, out_data/out_instr/out_ctrl and skid payload all 0, immediately, without waiting for clk.
REQ-028 reset deasserted mid-transfer: first edge after release behaves as EMPTY; entries held before reset are lost.

Configuration
REQ-029 Macro PIPE_STAGE_REG_SKID_EN defined: two-entry behaviour of REQ-018..REQ-026 and registered in_ready.
REQ-030 Macro undefined: skid register and SKID state removed; capacity 1; in_ready = out_ready | ~out_valid (combinational); occupancy max 1; flush and reset rules unchanged.

Verification
REQ-031 Reset: reset=1 with clk stopped -> out_valid=0, in_ready=1, occupancy=0, out_data=0 immediately.
REQ-032 Streaming: in_valid=1 every cycle, payloads 1,2,3,4, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, one-cycle latency, occupancy stays 1.
REQ-033 Backpressure (SKID_EN): send 0xA1,0xB2 with out_ready=0 -> occupancy 2, in_ready=0; out_ready=1 -> 0xA1 then 0xB2, in_ready=1 the cycle after 0xA1 leaves.
REQ-034 Flush: occupancy 2, flush=1 with in_valid=1 payload 0xC3 -> next cycle out_valid=0, occupancy 0; 0xC3 never appears.
REQ-035 Width sweep: DATA_W=16, NUM_DATA=4, INSTR_W=32, CTRL_W=5 -> all-ones and walking-1 payloads pass bit-exact.
REQ-036 Macro off: out_ready=0 with one entry held -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> entry replaced in one cycle, occupancy stays 1.
